tft_rect_writer: RTL and testbench
==================================

# tft_rect_writer

Responder side of the GUI drawing interface. It accepts a rectangle-fill request (window coordinates plus a per-pixel colour stream) from the GUI or plot front end. It programs an ILI9341-class controller over a 16-bit 8080 parallel bus: column address, page address, then memory write. It then streams one 16-bit colour per pixel, pulling each colour from the requester with `cnext`, and signals completion with `done`.

## Interface
Parameters:
- `WR_LOW`, default 1: cycles `tft_wrn` is held low per bus word (≥1).
- `WR_HIGH`, default 1: cycles `tft_wrn` is held high per bus word (≥1).

Ports:
- `clk`  in  1  clock.
- `arstn`  in  1  reset, asynchronous, active-low.
- `draw`  in  1  one-cycle request strobe; sampled only while `busy`=0.
- `xstart`, `xend`, `ystart`, `yend`  in  16 each  inclusive window, screen coordinates; latched on an accepted `draw`.
- `color`  in  16  RGB565 colour of the current pixel, valid combinationally from the source.
- `cnext`  out  1  one-cycle pulse: the current `color` has been consumed, so the source advances.
- `done`  out  1  one-cycle pulse: request finished.
- `busy`  out  1  request in progress.
- `tft_csn`  out  1  chip select, active-low.
- `tft_dcx`  out  1  0 = command word, 1 = data word.
- `tft_wrn`  out  1  write strobe; the panel latches on the rising edge.
- `tft_data`  out  16  bus data.

## Operation
- Reset values: `tft_csn`=1, `tft_wrn`=1, `tft_dcx`=1, `tft_data`=0, `cnext`=0, `done`=0, `busy`=0, FSM in IDLE. Reset mid-operation aborts immediately to these values. No partial recovery; the next `draw` restarts cleanly.
- States and transitions:
  - IDLE: an accepted `draw` moves to HDR, or to FIN if the window is invalid.
  - HDR: emits 11 header words, index 0..10.
  - PIX: emits N pixel words.
  - FIN: pulses `done`, then returns to IDLE.
- Header words, where `(v)` means `{8'h00, v}`:
  - 0: cmd 0x2A; 1–4: data `xstart[15:8]`, `xstart[7:0]`, `xend[15:8]`, `xend[7:0]`.
  - 5: cmd 0x2B; 6–9: the same four bytes for `ystart` and `yend`.
  - 10: cmd 0x2C.
- Pixel loop:
  - N = (xend−xstart+1)·(yend−ystart+1), counted with a 16-bit column counter and a 16-bit row counter. No multiplier.
  - Order is row-major, left to right, then top to bottom, matching panel auto-increment.
  - Each word is `tft_data` = `color`, `tft_dcx`=1.
- `cnext` pulses once per pixel word, during that word's first low cycle. It never pulses for header words. Exactly N pulses per request.
- Invalid window (`xend<xstart` or `ystart>yend`, unsigned): no bus activity, `busy` stays 0, and `done` pulses in the cycle after `draw`.
- `draw` while `busy`=1 is ignored. Coordinate and colour inputs may change freely after acceptance.
- No clipping to panel size; that is the requester's responsibility.

## Timing
- `draw` is high in cycle 0. On that edge the coordinates latch, `busy` rises, and `tft_csn` falls. Word 0 is driven with `tft_wrn` low from cycle 1.
- Word k, with W = WR_LOW+WR_HIGH:
  - low phase: cycles 1+kW … kW+WR_LOW.
  - high phase: the following WR_HIGH cycles.
  - `tft_data` and `tft_dcx` change only on the edge that starts a low phase, and stay stable through both phases.
- Back-to-back words: no idle cycle between one word's high phase and the next word's low phase.
- `done` pulses in cycle 1+(11+N)·W. With defaults this is cycle 23+2N.
- In that same cycle `busy` is 0 and `tft_csn` is 1, and a new `draw` in that cycle is accepted.
- `color` is registered into `tft_data` at the edge starting the low phase. The source sees `cnext` and updates at the following edge, which is at least WR_HIGH+WR_LOW−1 cycles before the next sample. A registered source with one cycle of latency is therefore safe.

## Structure
- Shared package `tft_pkg`:
  - commands `CMD_CASET`=8'h2A, `CMD_PASET`=8'h2B, `CMD_RAMWR`=8'h2C.
  - header length `HDR_WORDS`=11.
  - FSM state encodings IDLE/HDR/PIX/FIN.
- Sub-module `tft_bus_write`: a single-word 8080 strobe generator.
  - Inputs: `start`, `dcx`, `data`. Outputs: `csn`, `wrn`, bus lines, `ready`.
  - Owns the WR_LOW/WR_HIGH counter.
  - `ready` is asserted in the last high-phase cycle so the next word can start back-to-back.
- `tft_rect_writer` itself holds the FSM, the header index, the column/row counters and the header mux.

## Test plan
- Reset: assert `arstn`=0 mid-pixel-stream → all outputs return to reset values within the same cycle; no `done`; the next `draw` restarts at header word 0.
- 1×1 at (10,110), `color`=0xF800 → bus words in order: 0x002A, 0x0000, 0x000A, 0x0000, 0x000A, 0x002B, 0x0000, 0x006E, 0x0000, 0x006E, 0x002C, 0xF800. `tft_dcx` is 0 only for words 0, 5 and 10. One `cnext`; `done` in cycle 25.
- 40×40 button window (10,110)–(49,149) fed by a counter source advancing on `cnext` → 1600 pixel words carrying 0..1599 in order; 1600 `cnext` pulses; `done` in cycle 3223.
- Invalid window `xstart`=50, `xend`=10 → `tft_wrn` stays 1, `busy` stays 0, `done` in cycle 1.
- `draw` pulsed again mid-request with different coordinates → ignored, bus trace unchanged. A `draw` in the `done` cycle → accepted, with word 0 low in the next cycle.
- WR_LOW=2, WR_HIGH=3, 2×1 window → each word holds `tft_wrn` low 2 cycles and high 3 cycles; `done` in cycle 66.

Source files
------------

// File: rtl/tft_pkg.sv
// Shared definitions for the TFT rectangle writer: panel commands, header
// length, FSM states and the header word mux.
package tft_pkg;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_PASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam int unsigned HDR_WORDS = 11;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PIX,
        FIN
    } state_t;

    // Header word idx as {dcx, data}; address bytes go out high byte first.
    function automatic logic [16:0] hdr_word(
        input logic [3:0]  idx,
        input logic [15:0] xs,
        input logic [15:0] xe,
        input logic [15:0] ys,
        input logic [15:0] ye
    );
        logic [16:0] w;
        w = {1'b0, 8'h00, CMD_RAMWR};
        case (idx)
            4'd0:    w = {1'b0, 8'h00, CMD_CASET};
            4'd1:    w = {1'b1, 8'h00, xs[15:8]};
            4'd2:    w = {1'b1, 8'h00, xs[7:0]};
            4'd3:    w = {1'b1, 8'h00, xe[15:8]};
            4'd4:    w = {1'b1, 8'h00, xe[7:0]};
            4'd5:    w = {1'b0, 8'h00, CMD_PASET};
            4'd6:    w = {1'b1, 8'h00, ys[15:8]};
            4'd7:    w = {1'b1, 8'h00, ys[7:0]};
            4'd8:    w = {1'b1, 8'h00, ye[15:8]};
            4'd9:    w = {1'b1, 8'h00, ye[7:0]};
            default: w = {1'b0, 8'h00, CMD_RAMWR};
        endcase
        return w;
    endfunction

endpackage

// File: rtl/tft_bus_write.sv
// Single-word 8080 write strobe generator. A word starts on the edge where
// start is seen with ready high; wrn is then low WR_LOW cycles and high
// WR_HIGH cycles. ready is high while idle and in the last high cycle, so
// words can be chained with no gap. csn stays low across chained words.
module tft_bus_write #(
    parameter int unsigned WR_LOW  = 1,
    parameter int unsigned WR_HIGH = 1
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        start,
    input  logic        dcx,
    input  logic [15:0] data,
    output logic        csn,
    output logic        wrn,
    output logic        bus_dcx,
    output logic [15:0] bus_data,
    output logic        ready
);

    localparam logic [15:0] LOW_LAST  = 16'(WR_LOW - 1);
    localparam logic [15:0] HIGH_LAST = 16'(WR_HIGH - 1);

    logic        active;
    logic [15:0] cnt;

    assign ready = !active || (wrn && (cnt == HIGH_LAST));

    // Phase counter and bus registers; data/dcx only change at a word start.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            active   <= 1'b0;
            cnt      <= '0;
            csn      <= 1'b1;
            wrn      <= 1'b1;
            bus_dcx  <= 1'b1;
            bus_data <= '0;
        end else if (start && ready) begin
            active   <= 1'b1;
            cnt      <= '0;
            csn      <= 1'b0;
            wrn      <= 1'b0;
            bus_dcx  <= dcx;
            bus_data <= data;
        end else if (active) begin
            if (!wrn) begin
                if (cnt == LOW_LAST) begin
                    wrn <= 1'b1;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 16'd1;
                end
            end else if (cnt == HIGH_LAST) begin
                active <= 1'b0;
                csn    <= 1'b1;
            end else begin
                cnt <= cnt + 16'd1;
            end
        end
    end

endmodule

// File: rtl/tft_rect_writer.sv
// Rectangle fill writer for an ILI9341-class panel on a 16-bit 8080 bus:
// column/page address setup, memory write command, then one colour word per
// pixel pulled from the requester with cnext.
module tft_rect_writer #(
    parameter int unsigned WR_LOW  = 1,
    parameter int unsigned WR_HIGH = 1
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic        draw,
    input  logic [15:0] xstart,
    input  logic [15:0] xend,
    input  logic [15:0] ystart,
    input  logic [15:0] yend,
    input  logic [15:0] color,
    output logic        cnext,
    output logic        done,
    output logic        busy,
    output logic        tft_csn,
    output logic        tft_dcx,
    output logic        tft_wrn,
    output logic [15:0] tft_data
);

    import tft_pkg::*;

    state_t      state, state_nxt;
    logic [15:0] xs_r, xe_r, ys_r, ye_r;
    logic [15:0] col, row;
    logic [15:0] col_last, row_last;
    logic [3:0]  hdr_idx;
    logic        last_issued;
    logic        win_ok;
    logic        accept;
    logic        wr_start;
    logic        wr_dcx;
    logic [15:0] wr_data;
    logic        wr_ready;

    assign win_ok   = (xend >= xstart) && (yend >= ystart);
    assign accept   = draw && win_ok && ((state == IDLE) || (state == FIN));
    assign col_last = xe_r - xs_r;
    assign row_last = ye_r - ys_r;

    tft_bus_write #(
        .WR_LOW  (WR_LOW),
        .WR_HIGH (WR_HIGH)
    ) u_bus (
        .clk      (clk),
        .arstn    (arstn),
        .start    (wr_start),
        .dcx      (wr_dcx),
        .data     (wr_data),
        .csn      (tft_csn),
        .wrn      (tft_wrn),
        .bus_dcx  (tft_dcx),
        .bus_data (tft_data),
        .ready    (wr_ready)
    );

    // State register.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; FIN accepts a new draw just like IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FIN: begin
                if (draw) begin
                    state_nxt = win_ok ? HDR : FIN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            HDR: begin
                if (wr_ready && (hdr_idx == 4'(HDR_WORDS - 1))) begin
                    state_nxt = PIX;
                end
            end
            PIX: begin
                if (wr_ready && last_issued) begin
                    state_nxt = FIN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs and word issue: word 0 starts on the accepting edge itself.
    always_comb begin
        busy     = (state == HDR) || (state == PIX);
        done     = (state == FIN);
        wr_start = 1'b0;
        wr_dcx   = 1'b1;
        wr_data  = '0;
        case (state)
            IDLE, FIN: begin
                if (draw && win_ok) begin
                    wr_start          = 1'b1;
                    {wr_dcx, wr_data} = hdr_word(4'd0, xs_r, xe_r, ys_r, ye_r);
                end
            end
            HDR: begin
                if (wr_ready) begin
                    wr_start          = 1'b1;
                    {wr_dcx, wr_data} = hdr_word(hdr_idx, xs_r, xe_r, ys_r, ye_r);
                end
            end
            PIX: begin
                if (wr_ready && !last_issued) begin
                    wr_start = 1'b1;
                    wr_dcx   = 1'b1;
                    wr_data  = color;
                end
            end
            default: ;
        endcase
    end

    // Window latch, header index, row-major pixel counters and cnext pulse.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            xs_r        <= '0;
            xe_r        <= '0;
            ys_r        <= '0;
            ye_r        <= '0;
            col         <= '0;
            row         <= '0;
            hdr_idx     <= '0;
            last_issued <= 1'b0;
            cnext       <= 1'b0;
        end else begin
            cnext <= 1'b0;
            if (accept) begin
                xs_r        <= xstart;
                xe_r        <= xend;
                ys_r        <= ystart;
                ye_r        <= yend;
                col         <= '0;
                row         <= '0;
                hdr_idx     <= 4'd1;
                last_issued <= 1'b0;
            end else if ((state == HDR) && wr_ready) begin
                hdr_idx <= hdr_idx + 4'd1;
            end else if ((state == PIX) && wr_start) begin
                cnext <= 1'b1;
                if (col == col_last) begin
                    col <= '0;
                    if (row == row_last) begin
                        last_issued <= 1'b1;
                    end else begin
                        row <= row + 16'd1;
                    end
                end else begin
                    col <= col + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tft_rect_writer.sv
// Directed bench for tft_rect_writer: default-timing instance plus a
// WR_LOW=2/WR_HIGH=3 instance checked cycle by cycle.
module tb_tft_rect_writer;

    logic        clk = 1'b0;
    logic        arstn = 1'b0;
    logic        draw = 1'b0;
    logic [15:0] xstart = '0, xend = '0, ystart = '0, yend = '0;
    logic [15:0] color;
    logic        cnext, done, busy, tft_csn, tft_dcx, tft_wrn;
    logic [15:0] tft_data;

    logic        draw2 = 1'b0;
    logic [15:0] xs2 = 16'd3, xe2 = 16'd4, ys2 = 16'd7, ye2 = 16'd7;
    logic [15:0] color2 = 16'h1234;
    logic        cnext2, done2, busy2, csn2, dcx2, wrn2;
    logic [15:0] data2;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;

    logic        use_cnt = 1'b0;
    logic        src_clr = 1'b0;
    logic [15:0] src = '0;
    logic [15:0] color_const = '0;

    tft_rect_writer dut (
        .clk(clk), .arstn(arstn), .draw(draw),
        .xstart(xstart), .xend(xend), .ystart(ystart), .yend(yend),
        .color(color), .cnext(cnext), .done(done), .busy(busy),
        .tft_csn(tft_csn), .tft_dcx(tft_dcx), .tft_wrn(tft_wrn), .tft_data(tft_data)
    );

    tft_rect_writer #(.WR_LOW(2), .WR_HIGH(3)) dut2 (
        .clk(clk), .arstn(arstn), .draw(draw2),
        .xstart(xs2), .xend(xe2), .ystart(ys2), .yend(ye2),
        .color(color2), .cnext(cnext2), .done(done2), .busy(busy2),
        .tft_csn(csn2), .tft_dcx(dcx2), .tft_wrn(wrn2), .tft_data(data2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Counter colour source: advances once per consumed pixel.
    always @(posedge clk) begin
        if (src_clr) src <= '0;
        else if (cnext) src <= src + 16'd1;
    end

    assign color = use_cnt ? src : color_const;

    // Bus monitor for the default instance, sampled on the falling edge.
    logic [16:0] words[$];
    int unsigned falls[$];
    int unsigned dones[$];
    int          cnext_cnt = 0;
    int          busy_cnt = 0;
    logic        prev_wrn = 1'b1;

    always @(negedge clk) begin
        if (arstn) begin
            if (prev_wrn && !tft_wrn) falls.push_back(cyc);
            if (!prev_wrn && tft_wrn) words.push_back({tft_dcx, tft_data});
            if (cnext) cnext_cnt++;
            if (busy) busy_cnt++;
            if (done) dones.push_back(cyc);
        end
        prev_wrn = tft_wrn;
    end

    logic [16:0] hdr_1x1[11] = '{17'h0002A, 17'h10000, 17'h1000A, 17'h10000, 17'h1000A,
                                 17'h0002B, 17'h10000, 17'h1006E, 17'h10000, 17'h1006E,
                                 17'h0002C};
    logic [16:0] hdr_40[11]  = '{17'h0002A, 17'h10000, 17'h1000A, 17'h10000, 17'h10031,
                                 17'h0002B, 17'h10000, 17'h1006E, 17'h10000, 17'h10095,
                                 17'h0002C};
    logic [16:0] tbl2[13]    = '{17'h0002A, 17'h10000, 17'h10003, 17'h10000, 17'h10004,
                                 17'h0002B, 17'h10000, 17'h10007, 17'h10000, 17'h10007,
                                 17'h0002C, 17'h11234, 17'h11234};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic goto_cycle(input int unsigned n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_draw();
        draw = 1'b1;
        @(posedge clk);
        #1;
        draw = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " csn"},   32'(tft_csn), 32'd1);
        chk({tag, " wrn"},   32'(tft_wrn), 32'd1);
        chk({tag, " dcx"},   32'(tft_dcx), 32'd1);
        chk({tag, " data"},  32'(tft_data), 32'd0);
        chk({tag, " cnext"}, 32'(cnext), 32'd0);
        chk({tag, " done"},  32'(done), 32'd0);
        chk({tag, " busy"},  32'(busy), 32'd0);
    endtask

    int          bw, bf, bd, bc, bb;
    int unsigned t0, t1;

    initial begin
        // Reset state
        #12;
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        arstn = 1'b1;
        @(posedge clk); #1;

        // 1x1 window at (10,110)
        xstart = 16'd10; xend = 16'd10; ystart = 16'd110; yend = 16'd110;
        use_cnt = 1'b0; color_const = 16'hF800;
        bw = words.size(); bf = falls.size(); bd = dones.size(); bc = cnext_cnt;
        t0 = cyc;
        pulse_draw();
        goto_cycle(t0 + 28);
        chk("1x1 nwords", 32'(words.size() - bw), 32'd12);
        for (int i = 0; i < 11; i++) chk($sformatf("1x1 hdr%0d", i), 32'(words[bw + i]), 32'(hdr_1x1[i]));
        chk("1x1 pixel", 32'(words[bw + 11]), 32'h1F800);
        chk("1x1 cnext count", 32'(cnext_cnt - bc), 32'd1);
        chk("1x1 done count", 32'(dones.size() - bd), 32'd1);
        chk("1x1 done cycle", dones[bd] - t0, 32'd25);
        chk("1x1 word0 low", falls[bf] - t0, 32'd1);

        // 40x40 window with counter source, ignored mid-request draw,
        // and a new 1x1 draw accepted in the done cycle
        src_clr = 1'b1;
        @(posedge clk); #1;
        src_clr = 1'b0;
        use_cnt = 1'b1;
        xstart = 16'd10; xend = 16'd49; ystart = 16'd110; yend = 16'd149;
        bw = words.size(); bf = falls.size(); bd = dones.size(); bc = cnext_cnt;
        t0 = cyc;
        pulse_draw();
        goto_cycle(t0 + 500);
        xstart = 16'd0; xend = 16'd0; ystart = 16'd0; yend = 16'd0;
        pulse_draw();
        xstart = 16'd10; xend = 16'd10; ystart = 16'd110; yend = 16'd110;
        goto_cycle(t0 + 3223);
        chk("40x40 done at end", 32'(done), 32'd1);
        chk("40x40 busy at end", 32'(busy), 32'd0);
        chk("40x40 csn at end", 32'(tft_csn), 32'd1);
        use_cnt = 1'b0; color_const = 16'h07E0;
        t1 = cyc;
        pulse_draw();
        goto_cycle(t1 + 28);
        chk("40x40 nwords", 32'(words.size() - bw), 32'd1623);
        for (int i = 0; i < 11; i++) chk($sformatf("40x40 hdr%0d", i), 32'(words[bw + i]), 32'(hdr_40[i]));
        for (int i = 0; i < 1600; i++) chk($sformatf("40x40 pix%0d", i), 32'(words[bw + 11 + i]), {15'd0, 1'b1, 16'(i)});
        chk("40x40 cnext count", 32'(cnext_cnt - bc), 32'd1601);
        chk("40x40 done count", 32'(dones.size() - bd), 32'd2);
        chk("40x40 done cycle", dones[bd] - t0, 32'd3223);
        chk("b2b word0 low", falls[bf + 1611] - t1, 32'd1);
        chk("b2b done cycle", dones[bd + 1] - t1, 32'd25);
        for (int i = 0; i < 11; i++) chk($sformatf("b2b hdr%0d", i), 32'(words[bw + 1611 + i]), 32'(hdr_1x1[i]));
        chk("b2b pixel", 32'(words[bw + 1622]), 32'h107E0);

        // Invalid window: xend < xstart
        xstart = 16'd50; xend = 16'd10; ystart = 16'd0; yend = 16'd0;
        bw = words.size(); bf = falls.size(); bd = dones.size(); bc = cnext_cnt; bb = busy_cnt;
        t0 = cyc;
        pulse_draw();
        goto_cycle(t0 + 5);
        chk("inv done count", 32'(dones.size() - bd), 32'd1);
        chk("inv done cycle", dones[bd] - t0, 32'd1);
        chk("inv no words", 32'(words.size() - bw), 32'd0);
        chk("inv no wrn low", 32'(falls.size() - bf), 32'd0);
        chk("inv busy never", 32'(busy_cnt - bb), 32'd0);
        chk("inv no cnext", 32'(cnext_cnt - bc), 32'd0);

        // Reset during the pixel stream, then a clean restart
        xstart = 16'd0; xend = 16'd2; ystart = 16'd0; yend = 16'd2;
        color_const = 16'hABCD;
        t0 = cyc;
        pulse_draw();
        goto_cycle(t0 + 31);
        chk("midrst cnext before", 32'(cnext), 32'd1);
        #1 arstn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        bd = dones.size();
        @(posedge clk); #1;
        @(posedge clk); #1;
        arstn = 1'b1;
        goto_cycle(cyc + 5);
        chk("midrst no done", 32'(dones.size() - bd), 32'd0);
        xstart = 16'd10; xend = 16'd10; ystart = 16'd110; yend = 16'd110;
        color_const = 16'hF800;
        bw = words.size(); bf = falls.size(); bd = dones.size();
        t0 = cyc;
        pulse_draw();
        goto_cycle(t0 + 28);
        chk("restart nwords", 32'(words.size() - bw), 32'd12);
        chk("restart word0", 32'(words[bw]), 32'h0002A);
        chk("restart word0 low", falls[bf] - t0, 32'd1);
        chk("restart done cycle", dones[bd] - t0, 32'd25);

        // WR_LOW=2, WR_HIGH=3 instance, 2x1 window, cycle by cycle
        t0 = cyc;
        draw2 = 1'b1;
        @(posedge clk); #1;
        draw2 = 1'b0;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (c <= 65) begin
                int k, ph;
                k = (c - 1) / 5;
                ph = (c - 1) % 5;
                chk($sformatf("wr23 wrn c%0d", c),  32'(wrn2), (ph < 2) ? 32'd0 : 32'd1);
                chk($sformatf("wr23 data c%0d", c), 32'(data2), 32'(tbl2[k][15:0]));
                chk($sformatf("wr23 dcx c%0d", c),  32'(dcx2), 32'(tbl2[k][16]));
                chk($sformatf("wr23 csn c%0d", c),  32'(csn2), 32'd0);
                chk($sformatf("wr23 busy c%0d", c), 32'(busy2), 32'd1);
                chk($sformatf("wr23 cnext c%0d", c), 32'(cnext2), (k >= 11 && ph == 0) ? 32'd1 : 32'd0);
                chk($sformatf("wr23 done c%0d", c), 32'(done2), 32'd0);
            end else if (c == 66) begin
                chk("wr23 done c66", 32'(done2), 32'd1);
                chk("wr23 busy c66", 32'(busy2), 32'd0);
                chk("wr23 csn c66", 32'(csn2), 32'd1);
                chk("wr23 wrn c66", 32'(wrn2), 32'd1);
            end else begin
                chk($sformatf("wr23 done c%0d", c), 32'(done2), 32'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
